// File: rtl/dmem_sramlike_bridge_pkg.sv
// Shared definitions for the MEM-stage to SRAM-like data bus bridge.
// State encodings of the bridge FSM and the bus access size codes.
// No logic here; imported by the bridge and its bench.
package dmem_sramlike_bridge_pkg;

  // Bridge FSM states: idle, address phase, data phase, result held.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Access size codes shared by the CPU side and the bus side.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/dmem_sramlike_bridge.sv
// Purpose: turns a MEM-stage data access into one SRAM-like req/addr_ok/data_ok transaction.
// Latency: 4 cycles minimum (request, REQ, WAIT, DONE); longer with slave wait states.
// Backpressure: stalls the pipeline until data_ok, then holds the result while any stall persists.
module dmem_sramlike_bridge
  import dmem_sramlike_bridge_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  // MEM-stage side
  input  logic          cpu_en,
  input  logic [3:0]    cpu_wen,
  input  logic [1:0]    cpu_size,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_except,
  input  logic          cpu_longest_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  // SRAM-like bus side
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [AW-1:0] data_addr,
  output logic [DW-1:0] data_wdata,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  input  logic [DW-1:0] data_rdata
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [1:0]    size_q, size_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  // A new access is only started when MEM is not taking an exception this cycle.
  logic new_req;
  assign new_req = cpu_en && !cpu_except;

  // Next-state and request-register update; cpu_* are looked at only in IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (new_req) begin
          addr_d  = cpu_addr;
          wr_d    = |cpu_wen;
          size_d  = cpu_size;
          wdata_d = cpu_wdata;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (data_addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Captured for stores as well; the value is simply unused there.
        if (data_data_ok) begin
          rdata_d = data_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Keep the result until the whole pipeline is free to consume it.
        if (!cpu_longest_stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus fields come straight from the latched request so they stay stable until addr_ok.
  assign data_req   = (state_q == S_REQ);
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;

  // Stall covers the request cycle itself, so the pipeline freezes before REQ is entered.
  assign cpu_stall = ((state_q == S_IDLE) && new_req) ||
                     (state_q == S_REQ) || (state_q == S_WAIT);
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_sramlike_bridge.sv
// Bench for dmem_sramlike_bridge: memory-backed slave, reference memory and scoreboard.
// Expected bus fields and returned data are queued at issue and popped by a monitor.
// Slave wait states and held pipeline stalls are randomised per access.
module tb_dmem_sramlike_bridge;
  import dmem_sramlike_bridge_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en, cpu_except, ext_stall;
  logic [3:0]  cpu_wen;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, cpu_longest_stall;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;

  always #5 clk = ~clk;

  // The global stall includes the bridge's own request.
  assign cpu_longest_stall = cpu_stall | ext_stall;

  dmem_sramlike_bridge #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_except(cpu_except), .cpu_longest_stall(cpu_longest_stall),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  bus_t        exp_bus_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_last;
  logic [31:0] ref_mem[16];
  logic [31:0] slv_mem[16];

  // Slave controls
  int          ao_dly, do_dly, slv_cnt, slv_ph;
  bit          slv_kill, spur, slv_real, rd_pend;
  logic [31:0] slv_old;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bytes touched by an access of the given size at the given low address bits.
  function automatic logic [31:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 32'h0000_00FF << (8 * off);
      SZ_HALF: return 32'h0000_FFFF << (16 * off[1]);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Memory-backed SRAM-like slave; a store returns the word's previous contents.
  initial begin
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    slv_ph = 0; slv_cnt = 0; slv_real = 1'b0; slv_old = '0;
    forever begin
      @(posedge clk); #2;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; slv_real = 1'b0;
      data_rdata   = $urandom;
      if (slv_kill) begin slv_ph = 0; slv_kill = 1'b0; end
      if (spur) begin data_data_ok = 1'b1; spur = 1'b0; end
      if (slv_ph == 0 && data_req) begin slv_ph = 1; slv_cnt = ao_dly; end
      if (slv_ph == 1) begin
        if (slv_cnt == 0) begin
          data_addr_ok = 1'b1;
          slv_old = slv_mem[data_addr[5:2]];
          if (data_wr)
            slv_mem[data_addr[5:2]] = (slv_old & ~lane_mask(data_size, data_addr[1:0])) |
                                      (data_wdata & lane_mask(data_size, data_addr[1:0]));
          slv_ph  = 2;
          slv_cnt = do_dly;
        end else slv_cnt--;
      end else if (slv_ph == 2) begin
        slv_cnt--;
        if (slv_cnt == 0) begin
          data_data_ok = 1'b1; slv_real = 1'b1; data_rdata = slv_old; slv_ph = 0;
        end
      end
    end
  end

  // Monitor: bus fields against the queued request, result in the cycle after data_ok.
  initial begin
    bus_t e;
    rd_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rd_pend) begin
          rd_pend = 1'b0;
          if (exp_rd_q.size() == 0) check("rdata_unexpected", 32'd1, 32'd0);
          else check("rdata_done", cpu_rdata, exp_rd_q.pop_front());
          check("stall_in_done", 32'(cpu_stall), 32'd0);
        end
        if (data_data_ok && slv_real) rd_pend = 1'b1;
        if (data_req) begin
          if (exp_bus_q.size() == 0) check("req_unexpected", 32'd1, 32'd0);
          else begin
            e = exp_bus_q[0];
            check("bus_addr", data_addr, e.addr);
            check("bus_wr", 32'(data_wr), 32'(e.wr));
            check("bus_size", 32'(data_size), 32'(e.size));
            check("bus_wdata", data_wdata, e.wdata);
            if (data_addr_ok) void'(exp_bus_q.pop_front());
          end
        end
      end
    end
  end

  task automatic drive_garbage();
    {cpu_en, cpu_except, cpu_wen, cpu_size} = 8'($urandom);
    cpu_addr  = $urandom;
    cpu_wdata = $urandom;
  endtask

  // One MEM-stage access; lsx extra cycles of external stall hold the result in DONE.
  task automatic do_access(input logic [31:0] a, input logic [3:0] wen, input logic [1:0] sz,
                           input logic [31:0] wd, input int ao, input int dd, input int lsx);
    logic [31:0] old, m;
    bus_t        b;
    int          sc, rc;
    bit          done;
    @(posedge clk); #1;
    ao_dly = ao; do_dly = dd;
    cpu_en = 1'b1; cpu_except = 1'b0; cpu_wen = wen; cpu_size = sz;
    cpu_addr = a; cpu_wdata = wd; ext_stall = (lsx > 0);
    old = ref_mem[a[5:2]];
    m   = lane_mask(sz, a[1:0]);
    if (|wen) ref_mem[a[5:2]] = (old & ~m) | (wd & m);
    b.addr = a; b.wr = |wen; b.size = sz; b.wdata = wd;
    exp_bus_q.push_back(b);
    exp_rd_q.push_back(old);
    exp_last = old;
    sc = 0; rc = 0; done = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      if (cpu_stall) sc++;
      if (data_req) rc++;
      if (!cpu_stall) done = 1'b1;
      else begin @(posedge clk); #1; drive_garbage(); end
    end
    check("access_done", 32'(done), 32'd1);
    check("stall_cycles", 32'(sc), 32'(ao + 2 + dd));
    check("req_cycles", 32'(rc), 32'(ao + 1));
    for (int i = 0; i < lsx; i++) begin
      @(posedge clk); #1;
      drive_garbage();
      if (i == lsx - 1) ext_stall = 1'b0;
      @(negedge clk);
      check("hold_stall", 32'(cpu_stall), 32'd0);
      check("hold_req", 32'(data_req), 32'd0);
      check("hold_rdata", cpu_rdata, old);
    end
    cpu_en = 1'b0; cpu_except = 1'b0; cpu_wen = '0;
  endtask

  // Idle cycles with either no enable or an enable masked by an exception.
  task automatic idle_cycles(input int n, input bit spurious);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive_garbage();
      if (cpu_en) cpu_except = 1'b1;
      if (spurious && i == 0) spur = 1'b1;
      @(negedge clk);
      check("idle_stall", 32'(cpu_stall), 32'd0);
      check("idle_req", 32'(data_req), 32'd0);
      check("idle_rdata", cpu_rdata, exp_last);
    end
    cpu_en = 1'b0; cpu_except = 1'b0;
  endtask

  initial begin
    int          idx, off, sz;
    logic [31:0] a, m, wd;
    logic [3:0]  wen;
    rst = 1'b1; cpu_en = 1'b0; cpu_except = 1'b0; cpu_wen = '0; cpu_size = '0;
    cpu_addr = '0; cpu_wdata = '0; ext_stall = 1'b0; exp_last = '0;
    ao_dly = 0; do_dly = 1; slv_kill = 1'b0; spur = 1'b0;
    for (int i = 0; i < 16; i++) begin ref_mem[i] = $urandom; slv_mem[i] = ref_mem[i]; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall", 32'(cpu_stall), 32'd0);
    check("reset_req", 32'(data_req), 32'd0);
    check("reset_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Word load with slave wait states; byte store; result held under an MDU stall.
    do_access(32'h8000_0010, 4'b0000, SZ_WORD, 32'h0, 1, 3, 0);
    do_access(32'h8000_0003, 4'b0100, SZ_BYTE, 32'h00AB_0000, 2, 2, 0);
    do_access(32'h8000_0000, 4'b0000, SZ_WORD, 32'h0, 0, 1, 5);
    // Exception-masked enables and a spurious data_ok while idle.
    idle_cycles(3, 1'b1);
    // Back-to-back zero-wait loads.
    do_access(32'h8000_0010, 4'b0000, SZ_WORD, 32'h0, 0, 1, 0);
    do_access(32'h8000_0004, 4'b0000, SZ_WORD, 32'h0, 0, 1, 0);

    // Reset in WAIT: the in-flight read is abandoned and its late data_ok is ignored.
    @(posedge clk); #1;
    ao_dly = 0; do_dly = 6;
    cpu_en = 1'b1; cpu_except = 1'b0; cpu_wen = '0; cpu_size = SZ_WORD; cpu_addr = 32'h8000_0020;
    exp_bus_q.push_back({32'h8000_0020, 1'b0, SZ_WORD, cpu_wdata});
    @(negedge clk);
    @(posedge clk); #1; cpu_en = 1'b0;
    @(negedge clk);
    @(posedge clk); #1; rst = 1'b1; slv_kill = 1'b1;
    @(negedge clk);
    check("wait_stall_before_rst", 32'(cpu_stall), 32'd1);
    @(posedge clk); #1; rst = 1'b0; exp_last = '0;
    @(negedge clk);
    check("rst_req", 32'(data_req), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    idle_cycles(3, 1'b1);

    // Randomised mix of loads and stores with random wait states and held stalls.
    for (int t = 0; t < 40; t++) begin
      idx = $urandom_range(0, 15);
      sz  = $urandom_range(0, 2);
      off = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
      a   = 32'h8000_0000 | 32'(idx << 2) | 32'(off);
      m   = lane_mask(2'(sz), 2'(off));
      wen = $urandom_range(0, 1) ? {m[24], m[16], m[8], m[0]} : 4'b0000;
      wd  = $urandom & m;
      do_access(a, wen, 2'(sz), wd, $urandom_range(0, 3), $urandom_range(1, 4),
                $urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(2, 3), 1'b1);
    end

    idle_cycles(2, 1'b0);
    check("bus_q_empty", 32'(exp_bus_q.size()), 32'd0);
    check("rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
